// File: rtl/snn_interfaces_pkg.sv
// Shared SNN types: coordinates, packed feature-map words and the
// feature-map arbiter state encoding.
package snn_interfaces_pkg;

    localparam int DEFAULT_COORD_BITS  = 8;
    localparam int DEFAULT_CHANNELS    = 4;
    localparam int DEFAULT_NEURON_BITS = 8;

    typedef struct packed {
        logic [DEFAULT_COORD_BITS-1:0] y;
        logic [DEFAULT_COORD_BITS-1:0] x;
    } vec2_t;

    // Channel 0 sits in the least significant slice.
    typedef logic [DEFAULT_CHANNELS-1:0][DEFAULT_NEURON_BITS-1:0] feature_map_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_CAPTURE,
        RD_DONE,
        WR_ISSUE
    } fm_state_t;

endpackage

// File: rtl/fm_arbiter_addr_gen.sv
// Coordinate to linear feature-map address, with a range check against
// the image dimensions.
module fm_addr_gen #(
    parameter int COORD_BITS = 8,
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32,
    localparam int ADDR_BITS = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic [COORD_BITS-1:0] x_i,
    input  logic [COORD_BITS-1:0] y_i,
    output logic [ADDR_BITS-1:0]  addr_o,
    output logic                  oob_o
);

    logic [31:0] x_w;
    logic [31:0] y_w;

    assign x_w    = 32'(x_i);
    assign y_w    = 32'(y_i);
    assign oob_o  = (x_w >= 32'(IMG_WIDTH)) || (y_w >= 32'(IMG_HEIGHT));
    assign addr_o = ADDR_BITS'(y_w * 32'(IMG_WIDTH) + x_w);

endmodule

// File: rtl/fm_arbiter.sv
// Round-robin arbiter between one read and one write port onto a single
// feature-map memory. Optional counters enabled by FM_ARBITER_STATS_EN.
module fm_arbiter
    import snn_interfaces_pkg::*;
#(
    parameter int COORD_BITS       = DEFAULT_COORD_BITS,
    parameter int CHANNELS         = DEFAULT_CHANNELS,
    parameter int BITS_PER_CHANNEL = DEFAULT_NEURON_BITS,
    parameter int IMG_WIDTH        = 32,
    parameter int IMG_HEIGHT       = 32,
    localparam int ADDR_BITS       = $clog2(IMG_WIDTH * IMG_HEIGHT),
    localparam int WORD_BITS       = CHANNELS * BITS_PER_CHANNEL
) (
    input  logic                 clk,
    input  logic                 rst,
    input  vec2_t                coord_get,
    input  logic                 read_req,
    output feature_map_t         data_out,
    output logic                 read_ready,
    input  vec2_t                coord_wtr,
    input  feature_map_t         data_in,
    input  logic                 write_req,
    output logic                 write_ready,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [WORD_BITS-1:0] mem_wdata,
    input  logic [WORD_BITS-1:0] mem_rdata,
    output logic                 oob_err
`ifdef FM_ARBITER_STATS_EN
    ,
    output logic [31:0]          stat_reads,
    output logic [31:0]          stat_writes,
    output logic [31:0]          stat_conflicts
`endif
);

    fm_state_t             state_q;
    logic                  last_grant_q;   // 1 = write was granted last
    logic                  oob_q;
    feature_map_t          data_out_q;
    logic                  read_ready_q;
    logic                  write_ready_q;
    logic                  mem_en_q;
    logic                  mem_we_q;
    logic [ADDR_BITS-1:0]  mem_addr_q;
    logic [WORD_BITS-1:0]  mem_wdata_q;
    logic                  oob_err_q;

    logic                  grant_wr_d;
    logic                  grant_rd_d;
    vec2_t                 sel_coord_d;
    logic [ADDR_BITS-1:0]  sel_addr_d;
    logic                  sel_oob_d;

    assign grant_wr_d  = write_req && (!read_req || !last_grant_q);
    assign grant_rd_d  = read_req && !grant_wr_d;
    assign sel_coord_d = grant_wr_d ? coord_wtr : coord_get;

    fm_addr_gen #(
        .COORD_BITS (COORD_BITS),
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT)
    ) u_addr_gen (
        .x_i    (sel_coord_d.x),
        .y_i    (sel_coord_d.y),
        .addr_o (sel_addr_d),
        .oob_o  (sel_oob_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            oob_q         <= 1'b0;
            data_out_q    <= '0;
            read_ready_q  <= 1'b0;
            write_ready_q <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            oob_err_q     <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a state re-asserts them.
            read_ready_q  <= 1'b0;
            write_ready_q <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            oob_err_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_wr_d) begin
                        state_q       <= WR_ISSUE;
                        last_grant_q  <= 1'b1;
                        oob_q         <= sel_oob_d;
                        mem_addr_q    <= sel_addr_d;
                        mem_en_q      <= !sel_oob_d;
                        mem_we_q      <= !sel_oob_d;
                        write_ready_q <= 1'b1;
                        oob_err_q     <= sel_oob_d;
                        if (!sel_oob_d) begin
                            mem_wdata_q <= WORD_BITS'(data_in);
                        end
                    end else if (grant_rd_d) begin
                        state_q      <= RD_ISSUE;
                        last_grant_q <= 1'b0;
                        oob_q        <= sel_oob_d;
                        mem_addr_q   <= sel_addr_d;
                        mem_en_q     <= !sel_oob_d;
                    end
                end
                RD_ISSUE: begin
                    state_q <= RD_CAPTURE;
                end
                RD_CAPTURE: begin
                    state_q      <= RD_DONE;
                    data_out_q   <= oob_q ? '0 : feature_map_t'(mem_rdata);
                    read_ready_q <= 1'b1;
                    oob_err_q    <= oob_q;
                end
                RD_DONE: begin
                    state_q <= IDLE;
                end
                WR_ISSUE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_out    = data_out_q;
    assign read_ready  = read_ready_q;
    assign write_ready = write_ready_q;
    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign oob_err     = oob_err_q;

`ifdef FM_ARBITER_STATS_EN
    logic [31:0] stat_reads_q;
    logic [31:0] stat_writes_q;
    logic [31:0] stat_conflicts_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_reads_q     <= '0;
            stat_writes_q    <= '0;
            stat_conflicts_q <= '0;
        end else begin
            if (state_q == RD_DONE && stat_reads_q != '1) begin
                stat_reads_q <= stat_reads_q + 32'd1;
            end
            if (state_q == WR_ISSUE && stat_writes_q != '1) begin
                stat_writes_q <= stat_writes_q + 32'd1;
            end
            if (state_q == IDLE && read_req && write_req && stat_conflicts_q != '1) begin
                stat_conflicts_q <= stat_conflicts_q + 32'd1;
            end
        end
    end

    assign stat_reads     = stat_reads_q;
    assign stat_writes    = stat_writes_q;
    assign stat_conflicts = stat_conflicts_q;
`endif

endmodule
